// File: rtl/gpio_mulcore.sv
// gpio_mulcore: register-mapped sequential multiplier with GPIO capture.
// A1 x A2 is computed by an unsigned shift-add engine, one multiplier bit
// per clock. W receives the low RES_W product bits and L their popcount.
// Optional feature macro: GPIO_MULCORE_IRQ_EN adds the irq port and the
// STATUS irq_pend bit (bit 4); without it bit 4 reads 0.
module gpio_mulcore #(
    parameter int          OP_W  = 24,
    parameter int          RES_W = 32,
    parameter logic [15:0] BASE  = 16'h0380
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out,
    input  logic [31:0] gpio_in,
    input  logic        gpio_latch,
    output logic [31:0] gpio_in_s_insp,
    output logic [31:0] gpio_out
`ifdef GPIO_MULCORE_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int PW    = 2 * OP_W;
    localparam int CNT_W = $clog2(OP_W + 1);

    localparam logic [15:0] ADDR_A1   = BASE;
    localparam logic [15:0] ADDR_A2   = BASE + 16'h0008;
    localparam logic [15:0] ADDR_W    = BASE + 16'h0010;
    localparam logic [15:0] ADDR_L    = BASE + 16'h0018;
    localparam logic [15:0] ADDR_CTRL = BASE + 16'h0020;

    typedef enum logic [1:0] {IDLE, MULT, POP, DONE} state_t;

    state_t             state_q, state_d;
    logic [OP_W-1:0]    a1_q, a2_q;
    logic [PW-1:0]      mcand_q;
    logic [OP_W-1:0]    mplier_q;
    logic [PW-1:0]      prod_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RES_W-1:0]   w_q;
    logic [5:0]         l_q;
    logic               valid_q, err_q, busy_q, ready_q;
    logic [15:0]        op_count_q;
    logic [31:0]        gpio_in_s;
    logic [31:0]        rd_data;
    logic               status_irq;

    logic hit_a1, hit_a2, hit_w, hit_l, hit_ctrl;
    logic start_wr, start_ok, hi_zero;

    // Number of set bits in a result word.
    function automatic logic [5:0] popcount(input logic [RES_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < RES_W; i++)
            n = n + 6'(v[i]);
        return n;
    endfunction

    assign hit_a1   = (saddress == ADDR_A1);
    assign hit_a2   = (saddress == ADDR_A2);
    assign hit_w    = (saddress == ADDR_W);
    assign hit_l    = (saddress == ADDR_L);
    assign hit_ctrl = (saddress == ADDR_CTRL);

    assign start_wr = swr && hit_ctrl && sdata_in[0];
    assign start_ok = start_wr && (state_q == IDLE);
    // Overflow check: bits above RES_W must be zero (trivially true when RES_W == PW).
    assign hi_zero  = ((prod_q >> RES_W) == '0);

    assign gpio_out       = {16'h0000, op_count_q};
    assign gpio_in_s_insp = gpio_in_s;

    // Bits of sdata_in above the operand width are never stored.
    logic unused_sdata;
    assign unused_sdata = ^sdata_in;

    // FSM state register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state: MULT runs exactly OP_W steps, then one POP and one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = MULT;
            MULT: if (cnt_q == CNT_W'(OP_W - 1)) state_d = POP;
            POP:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand registers, written directly from the bus at any time.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a1_q <= '0;
            a2_q <= '0;
        end else if (swr) begin
            if (hit_a1) a1_q <= sdata_in[OP_W-1:0];
            if (hit_a2) a2_q <= sdata_in[OP_W-1:0];
        end
    end

    // Shift-add engine: shadows load on start so later A1/A2 writes do not disturb it.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            w_q      <= '0;
            l_q      <= '0;
        end else if (start_ok) begin
            mcand_q  <= PW'(a1_q);
            mplier_q <= a2_q;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (state_q == MULT) begin
            if (mplier_q[0]) prod_q <= prod_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end else if (state_q == POP) begin
            w_q <= prod_q[RES_W-1:0];
            l_q <= popcount(prod_q[RES_W-1:0]);
        end
    end

    // Status flags and completion counter.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            op_count_q <= '0;
        end else begin
            if (start_ok) begin
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else if (start_wr) begin
                err_q <= 1'b1;
            end
            if (state_q == POP) valid_q <= hi_zero;
            if (state_q == DONE) begin
                busy_q     <= 1'b0;
                ready_q    <= 1'b1;
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

`ifdef GPIO_MULCORE_IRQ_EN
    logic irq_pend_q;

    // Completion interrupt: set on DONE, cleared by STATUS read or accepted start.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)                              irq_pend_q <= 1'b0;
        else if (state_q == DONE)                  irq_pend_q <= 1'b1;
        else if ((srd && hit_ctrl) || start_ok)    irq_pend_q <= 1'b0;
    end

    assign irq        = irq_pend_q;
    assign status_irq = irq_pend_q;
`else
    assign status_irq = 1'b0;
`endif

    // Read mux: unmapped addresses return zero.
    always_comb begin
        rd_data = '0;
        if (hit_a1)   rd_data = 32'(a1_q);
        if (hit_a2)   rd_data = 32'(a2_q);
        if (hit_w)    rd_data = 32'(w_q);
        if (hit_l)    rd_data = 32'(l_q);
        if (hit_ctrl) rd_data = {27'h0, status_irq, err_q, busy_q, ready_q, valid_q};
    end

    // Registered read data, capturing pre-write register contents.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)  sdata_out <= '0;
        else if (srd)  sdata_out <= rd_data;
    end

    // GPIO input capture.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)        gpio_in_s <= '0;
        else if (gpio_latch) gpio_in_s <= gpio_in;
    end

endmodule

// File: doc/gpio_mulcore.md
GPIO_MULCORE -- requirements
Module: gpio_mulcore

Interface
REQ-001 Parameter OP_W, 24, operand width in bits (1..32).
REQ-002 Parameter RES_W, 32, result width exposed on the bus (1..32, <= 2*OP_W).
REQ-003 Parameter BASE, 16'h0380, register-block base address.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 n_reset  in  1  reset, asynchronous, active-low.
REQ-006 saddress  in  16  register address.
REQ-007 srd  in  1  read strobe, one clk cycle high per access.
REQ-008 swr  in  1  write strobe, one clk cycle high per access.
REQ-009 sdata_in  in  32  write data.
REQ-010 sdata_out  out  32  registered read data.
REQ-011 gpio_in  in  32  external input bus.
REQ-012 gpio_latch  in  1  capture enable for gpio_in.
REQ-013 gpio_in_s_insp  out  32  captured gpio_in.
REQ-014 gpio_out  out  32  {16'h0, op_count}.
REQ-015 irq  out  1  completion interrupt, present only with GPIO_MULCORE_IRQ_EN.

Function
REQ-016 Register map: BASE+0x00 A1 (RW), +0x08 A2 (RW), +0x10 W (RO), +0x18 L (RO), +0x20 CTRL (W: bit0 start) / STATUS (R).
REQ-017 A1/A2 store sdata_in[OP_W-1:0]; read back zero-extended; unmapped reads return 0; unmapped writes ignored.
REQ-018 sdata_out updated the cycle after srd with the pre-write value of the addressed register; held otherwise.
REQ-019 STATUS = {27'h0, irq_pend, err, busy, ready, valid}; bits 4..0.
REQ-020 FSM states IDLE, MULT, POP, DONE; IDLE->MULT on start write; MULT->POP after exactly OP_W cycles; POP->DONE after 1 cycle; DONE->IDLE after 1 cycle.
REQ-021 On start: operands copied to internal shadows, busy=1, ready=0, valid=0, err cleared; A1/A2 writes during busy update registers but not the running operation.
REQ-022 MULT: unsigned shift-add, one multiplier bit per cycle, LSB first, 2*OP_W-bit product.
REQ-023 POP: W = product[RES_W-1:0]; valid = (product[2*OP_W-1:RES_W] == 0), valid=1 when RES_W = 2*OP_W; L = popcount(W), zero-extended to 32.
REQ-024 DONE: busy=0, ready=1, op_count incremented (16-bit, wraps 0xFFFF->0x0000).
REQ-025 Latency: ready asserts OP_W+2 cycles after the cycle carrying the start write.
REQ-026 Start write while busy: ignored, err=1 (sticky until next accepted start).
REQ-027 srd and swr same cycle, same address: write takes effect, read returns old value.
REQ-028 STATUS read in same cycle ready rises returns ready=0.
REQ-029 W and L hold the previous result until POP of the next operation.
REQ-030 gpio_in_s captured from gpio_in on each clk edge where gpio_latch=1; held otherwise.

Reset
REQ-031 n_reset low: all registers, W, L, op_count, sdata_out, gpio_in_s, irq_pend = 0; FSM = IDLE; ready=1, busy=0, valid=0, err=0; immediate, independent of clk.
REQ-032 Reset during MULT/POP aborts the operation; op_count not incremented.

Configuration
REQ-033 GPIO_MULCORE_IRQ_EN defined: irq port present; irq_pend set in DONE, cleared by STATUS read or accepted start; irq = irq_pend.
REQ-034 GPIO_MULCORE_IRQ_EN undefined: no irq port; STATUS bit4 reads 0; all other behaviour identical.

Verification
REQ-035 Defaults; A1=3, A2=5, start -> after 26 cycles ready=1, W=0x0000000F, L=4, valid=1, gpio_out=0x00000001.
REQ-036 A1=A2=0xFFFFFF, start -> W=0xFE000001, valid=0, L=8.
REQ-037 Start, then start again 5 cycles later -> second ignored, err=1, first result correct, op_count +1 only.
REQ-038 n_reset pulsed mid-MULT -> STATUS=0x02, W=0, gpio_out=0; new start completes normally.
REQ-039 op_count preset to 0xFFFF via 65535 runs -> next completion gives gpio_out=0x00000000.
REQ-040 IRQ_EN build: completion -> irq=1; STATUS read returns bit4=1, irq=0 next cycle.
